tx_hop_scheduler: RTL
=====================

TX_HOP_SCHEDULER -- requirements
Module: tx_hop_scheduler

Interface
REQ-001 SHALL have parameter NUMBER_OF_SLOTS, default 8: slot-table depth; power of two, 2..16.
REQ-002 SHALL have parameter DWELL_WIDTH, default 16: width of the per-slot dwell count.
REQ-003 SHALL have port clock, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: begin the schedule; sampled only in IDLE.
REQ-006 SHALL have port stop, input, 1: abort the schedule; sampled in LOAD and RUN.
REQ-007 SHALL have port num_slots, input, $clog2(NUMBER_OF_SLOTS): active slots minus 1; latched on an accepted start.
REQ-008 SHALL have port cfg_wr_en, input, 1: slot-table write strobe.
REQ-009 SHALL have port cfg_addr, input, $clog2(NUMBER_OF_SLOTS): slot-table write address.
REQ-010 SHALL have port cfg_sel, input, 3: output_select code written to the slot.
REQ-011 SHALL have port cfg_phase_inc, input, 16: DDS phase increment written to the slot.
REQ-012 SHALL have port cfg_dwell, input, DWELL_WIDTH: slot duration in clock cycles.
REQ-013 SHALL have port cfg_ready, output, 1: high in IDLE, meaning table writes are accepted.
REQ-014 SHALL have port output_select, output, 3: source select driven to the TX core.
REQ-015 SHALL have ports dds_phase_inc1, dds_phase_inc2 and dds_phase_inc3, output, 16 each: per-channel frequency-shift increments.
REQ-016 SHALL have port slot_index, output, $clog2(NUMBER_OF_SLOTS): index of the active slot.
REQ-017 SHALL have port slot_strobe, output, 1: one-cycle pulse on the cycle the outputs take a new slot's values.
REQ-018 SHALL have port busy, output, 1: high in LOAD and RUN.
REQ-019 SHALL have port done, output, 1: one-cycle pulse when the schedule completes or is stopped.

Function
REQ-020 SHALL implement states IDLE, LOAD and RUN.
REQ-021 Transitions SHALL be: IDLE->LOAD on start; LOAD->RUN after exactly 1 cycle; RUN->IDLE on stop or on the end of the last slot (loop disabled).
REQ-022 SHALL store cfg_sel, cfg_phase_inc and cfg_dwell at cfg_addr when cfg_wr_en is high in IDLE; SHALL ignore writes in LOAD and RUN.
REQ-023 A start sampled at cycle t SHALL produce slot_strobe, slot_index=0 and slot-0 outputs at cycle t+2, with busy high from t+1.
REQ-024 Each slot SHALL hold its outputs for max(dwell,1) cycles; dwell=0 SHALL behave as dwell=1.
REQ-025 At the end of a slot, the next slot's outputs and slot_strobe SHALL appear on the immediately following cycle, with no gap cycle.
REQ-026 Slot phase_inc SHALL update only the channel mapped from its sel (1,4->inc1; 2,5->inc2; 3,6->inc3); other sel codes SHALL leave all increments unchanged.
REQ-027 output_select SHALL be driven with the slot sel verbatim; all outputs SHALL be registered.
REQ-028 slot_index SHALL advance 0..num_slots; num_slots=0 SHALL give a single-slot schedule.
REQ-029 start while busy SHALL be ignored; start and stop in the same IDLE cycle SHALL leave the block in IDLE.
REQ-030 stop in LOAD or RUN SHALL move to IDLE on the next cycle, pulse done, and hold output_select and the increments at their last values.
REQ-031 A cfg_wr_en coincident with an accepted start SHALL be written, but that write SHALL not affect slot 0 of the run that start begins.

Reset
REQ-032 On reset: state=IDLE, output_select=1, dds_phase_inc1/2/3=0, slot_index=0, slot_strobe=0, busy=0, done=0, cfg_ready=1.
REQ-033 On reset, all table entries SHALL be cleared to sel=0, phase_inc=0, dwell=0.
REQ-034 Reset asserted mid-RUN SHALL abort without a done pulse.

Configuration
REQ-035 Macro TX_HOP_SCHED_LOOP_EN defined: after the last slot, the schedule SHALL wrap to slot 0 with no gap and run until stop; done SHALL pulse only on stop.
REQ-036 Macro TX_HOP_SCHED_LOOP_EN undefined: after the last slot's dwell, the block SHALL return to IDLE, pulse done once, and hold its outputs.

Verification
REQ-037 Load slot0={4,0x1000,3} and slot1={5,0x2000,2}, num_slots=1, start at t -> at t+2 output_select=4 and inc1=0x1000 for 3 cycles; then output_select=5 and inc2=0x2000 for 2 cycles; done pulses (loop off).
REQ-038 Same table with TX_HOP_SCHED_LOOP_EN defined -> slot sequence 0,1,0,1... with strobe period 3/2 cycles; stop -> IDLE next cycle with a done pulse.
REQ-039 dwell=0 in every slot, num_slots=7 -> slot_strobe high 8 consecutive cycles; slot_index 0..7.
REQ-040 cfg write to slot 0 during RUN -> table unchanged; next run still uses the old slot-0 values.
REQ-041 Assert reset mid-RUN -> next cycle output_select=1, all increments 0, busy=0, no done pulse.

Source files
------------

// File: rtl/tx_hop_scheduler_if.sv
// tx_hop_scheduler_if
//   Groups the slot-table configuration port, the schedule control inputs and
//   the TX-core facing outputs of tx_hop_scheduler.
//   master : driver side (controller / testbench) - drives start/stop/cfg_*
//   slave  : scheduler side - drives cfg_ready, output_select, dds_phase_inc*,
//            slot_index, slot_strobe, busy, done
//   NUMBER_OF_SLOTS and DWELL_WIDTH must match the scheduler instance.
interface tx_hop_scheduler_if #(
  parameter int unsigned NUMBER_OF_SLOTS = 8,
  parameter int unsigned DWELL_WIDTH     = 16
);
  localparam int unsigned IW = $clog2(NUMBER_OF_SLOTS);

  logic                   start;
  logic                   stop;
  logic [IW-1:0]          num_slots;
  logic                   cfg_wr_en;
  logic [IW-1:0]          cfg_addr;
  logic [2:0]             cfg_sel;
  logic [15:0]            cfg_phase_inc;
  logic [DWELL_WIDTH-1:0] cfg_dwell;

  logic                   cfg_ready;
  logic [2:0]             output_select;
  logic [15:0]            dds_phase_inc1;
  logic [15:0]            dds_phase_inc2;
  logic [15:0]            dds_phase_inc3;
  logic [IW-1:0]          slot_index;
  logic                   slot_strobe;
  logic                   busy;
  logic                   done;

  modport master (
    output start, stop, num_slots, cfg_wr_en, cfg_addr, cfg_sel, cfg_phase_inc, cfg_dwell,
    input  cfg_ready, output_select, dds_phase_inc1, dds_phase_inc2, dds_phase_inc3,
           slot_index, slot_strobe, busy, done
  );

  modport slave (
    input  start, stop, num_slots, cfg_wr_en, cfg_addr, cfg_sel, cfg_phase_inc, cfg_dwell,
    output cfg_ready, output_select, dds_phase_inc1, dds_phase_inc2, dds_phase_inc3,
           slot_index, slot_strobe, busy, done
  );
endinterface

// File: rtl/tx_hop_scheduler.sv
// tx_hop_scheduler
//   Frequency-hop slot scheduler. A slot table (sel, phase_inc, dwell) is
//   written while idle; on start the slots 0..num_slots are played out, each
//   for max(dwell,1) cycles, driving output_select and the DDS increment of
//   the channel the slot's sel maps to (1,4->inc1; 2,5->inc2; 3,6->inc3).
// Ports
//   clock : rising-edge clock
//   reset : synchronous active-high reset (clears state and slot table)
//   bus   : tx_hop_scheduler_if.slave (control, table write, TX outputs)
// Build option
//   TX_HOP_SCHED_LOOP_EN : when defined the schedule wraps from the last
//   slot back to slot 0 and runs until stop; otherwise it ends after the
//   last slot with a done pulse.
module tx_hop_scheduler #(
  parameter int unsigned NUMBER_OF_SLOTS = 8,
  parameter int unsigned DWELL_WIDTH     = 16
) (
  input logic             clock,
  input logic             reset,
  tx_hop_scheduler_if.slave bus
);
  localparam int unsigned IW = $clog2(NUMBER_OF_SLOTS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          num_q, num_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]             sel_q, sel_d;
  logic [15:0]            inc1_q, inc1_d;
  logic [15:0]            inc2_q, inc2_d;
  logic [15:0]            inc3_q, inc3_d;
  logic                   strobe_q, strobe_d;
  logic                   done_q, done_d;
  logic                   busy_q, rdy_q;

  logic [2:0]             tbl_sel_q [NUMBER_OF_SLOTS];
  logic [15:0]            tbl_inc_q [NUMBER_OF_SLOTS];
  logic [DWELL_WIDTH-1:0] tbl_dw_q  [NUMBER_OF_SLOTS];

  // Slot 0 is captured when start is accepted, so a table write landing on
  // the same edge as start cannot leak into the first slot of that run.
  logic [2:0]             s0_sel_q;
  logic [15:0]            s0_inc_q;
  logic [DWELL_WIDTH-1:0] s0_dw_q;

  logic                   accept;
  logic                   load;
  logic [IW-1:0]          nidx;
  logic [2:0]             esel;
  logic [15:0]            einc;
  logic [DWELL_WIDTH-1:0] edw;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    inc1_d   = inc1_q;
    inc2_d   = inc2_q;
    inc3_d   = inc3_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    accept   = 1'b0;
    load     = 1'b0;
    nidx     = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          accept  = 1'b1;
          state_d = S_LOAD;
          num_d   = bus.num_slots;
        end
      end
      S_LOAD: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          if (idx_q == num_q) begin
`ifdef TX_HOP_SCHED_LOOP_EN
            load = 1'b1;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            load = 1'b1;
            nidx = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q - DWELL_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (nidx == '0) begin
      esel = s0_sel_q;
      einc = s0_inc_q;
      edw  = s0_dw_q;
    end else begin
      esel = tbl_sel_q[nidx];
      einc = tbl_inc_q[nidx];
      edw  = tbl_dw_q[nidx];
    end

    if (load) begin
      idx_d    = nidx;
      sel_d    = esel;
      strobe_d = 1'b1;
      // Counter holds remaining cycles after this one; dwell 0 acts as 1.
      cnt_d    = (edw == '0) ? '0 : edw - DWELL_WIDTH'(1);
      case (esel)
        3'd1, 3'd4: inc1_d = einc;
        3'd2, 3'd5: inc2_d = einc;
        3'd3, 3'd6: inc3_d = einc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      num_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      sel_q    <= 3'd1;
      inc1_q   <= '0;
      inc2_q   <= '0;
      inc3_q   <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b1;
      s0_sel_q <= '0;
      s0_inc_q <= '0;
      s0_dw_q  <= '0;
      for (int unsigned i = 0; i < NUMBER_OF_SLOTS; i++) begin
        tbl_sel_q[i] <= '0;
        tbl_inc_q[i] <= '0;
        tbl_dw_q[i]  <= '0;
      end
    end else begin
      num_q    <= num_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      inc1_q   <= inc1_d;
      inc2_q   <= inc2_d;
      inc3_q   <= inc3_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      busy_q   <= (state_d != S_IDLE);
      rdy_q    <= (state_d == S_IDLE);
      if (accept) begin
        s0_sel_q <= tbl_sel_q[0];
        s0_inc_q <= tbl_inc_q[0];
        s0_dw_q  <= tbl_dw_q[0];
      end
      if (state_q == S_IDLE && bus.cfg_wr_en) begin
        tbl_sel_q[bus.cfg_addr] <= bus.cfg_sel;
        tbl_inc_q[bus.cfg_addr] <= bus.cfg_phase_inc;
        tbl_dw_q[bus.cfg_addr]  <= bus.cfg_dwell;
      end
    end
  end

  assign bus.cfg_ready      = rdy_q;
  assign bus.output_select  = sel_q;
  assign bus.dds_phase_inc1 = inc1_q;
  assign bus.dds_phase_inc2 = inc2_q;
  assign bus.dds_phase_inc3 = inc3_q;
  assign bus.slot_index     = idx_q;
  assign bus.slot_strobe    = strobe_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
endmodule
